// File: rtl/tero_pkg.sv
// Shared types and default constants for the TERO sweep controller.
package tero_pkg;

   localparam int unsigned DEF_N_TERO_BITS    = 32;
   localparam int unsigned DEF_N_TEROS        = 16;
   localparam int unsigned DEF_CHALLENGE_BITS = 4;
   localparam int unsigned DEF_SETTLE_CYCLES  = 16;
   localparam int unsigned DEF_WINDOW_CYCLES  = 1024;
   localparam int unsigned DEF_CNT_BITS       = 16;

   typedef enum logic [2:0] {
      StIdle,
      StRstIdx,
      StSettle,
      StCount,
      StEmit,
      StAdvance,
      StFinish
   } state_e;

   typedef struct packed {
      logic [DEF_N_TERO_BITS-1:0]    index;
      logic [DEF_CNT_BITS-1:0]       count;
      logic [DEF_CHALLENGE_BITS-1:0] challenge;
   } meas_rec_t;

endpackage

// File: rtl/tero_sweep_ctrl_if.sv
// Valid/ready measurement-record channel from the sweep controller to post-processing.
interface tero_sweep_ctrl_if #(
   parameter int unsigned N_TERO_BITS    = 32,
   parameter int unsigned CNT_BITS       = 16,
   parameter int unsigned CHALLENGE_BITS = 4
);

   logic                      meas_valid;
   logic                      meas_ready;
   logic [N_TERO_BITS-1:0]    meas_index;
   logic [CNT_BITS-1:0]       meas_count;
   logic [CHALLENGE_BITS-1:0] meas_challenge;

   modport master (
      output meas_valid,
      output meas_index,
      output meas_count,
      output meas_challenge,
      input  meas_ready
   );

   modport slave (
      input  meas_valid,
      input  meas_index,
      input  meas_count,
      input  meas_challenge,
      output meas_ready
   );

endinterface

// File: rtl/tero_edge_counter.sv
// Synchronizes the asynchronous TERO output and counts its rising edges, saturating at all-ones.
module tero_edge_counter #(
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                osc,
   input  logic                clr,
   input  logic                en,
   output logic [CNT_BITS-1:0] count_next
);

   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic                sync1_q;
   logic                sync2_q;
   logic                prev_q;
   logic                rise;
   logic [CNT_BITS-1:0] count_q;

   assign rise = sync2_q & ~prev_q;

   // count_next includes an edge seen this cycle so the caller can capture the final window value
   always_comb begin
      count_next = count_q;
      if (clr) begin
         count_next = '0;
      end else if (en && rise && (count_q != CNT_MAX)) begin
         count_next = count_q + CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         count_q <= '0;
      end else begin
         sync1_q <= osc;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         count_q <= count_next;
      end
   end

endmodule

// File: rtl/tero_sweep_ctrl.sv
// Sweeps all TEROs via the external index counter, counts oscillator edges per TERO and
// emits one measurement record per TERO over a valid/ready channel.
module tero_sweep_ctrl
   import tero_pkg::*;
#(
   parameter int unsigned N_TERO_BITS    = DEF_N_TERO_BITS,
   parameter int unsigned N_TEROS        = DEF_N_TEROS,
   parameter int unsigned CHALLENGE_BITS = DEF_CHALLENGE_BITS,
   parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
   parameter int unsigned CNT_BITS       = DEF_CNT_BITS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [CHALLENGE_BITS-1:0] challenge_in,
   input  logic [N_TERO_BITS-1:0]    tero_sel,
   output logic                      idx_reset,
   output logic                      idx_increment,
   output logic                      tero_en,
   input  logic                      tero_osc_in,
   output logic                      busy,
   output logic                      done,
   tero_sweep_ctrl_if.master         meas
);

   localparam int unsigned MAX_CYC  = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES
                                                                      : WINDOW_CYCLES;
   localparam int unsigned CYC_BITS = $clog2(MAX_CYC + 1);

   localparam logic [CYC_BITS-1:0]    SETTLE_LAST = CYC_BITS'(SETTLE_CYCLES - 1);
   localparam logic [CYC_BITS-1:0]    WINDOW_LAST = CYC_BITS'(WINDOW_CYCLES - 1);
   localparam logic [N_TERO_BITS-1:0] LAST_IDX    = N_TERO_BITS'(N_TEROS - 1);

   state_e              state_q;
   state_e              state_d;
   logic [CYC_BITS-1:0] cyc_q;
   logic [CNT_BITS-1:0] cnt_next;
   logic                window_end;

   assign window_end = (state_q == StCount) && (cyc_q == WINDOW_LAST);

   tero_edge_counter #(
      .CNT_BITS (CNT_BITS)
   ) u_edge_counter (
      .clk        (clk),
      .reset      (reset),
      .osc        (tero_osc_in),
      .clr        (state_q == StSettle),
      .en         (state_q == StCount),
      .count_next (cnt_next)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StRstIdx;
         StRstIdx:  state_d = StSettle;
         StSettle:  if (cyc_q == SETTLE_LAST) state_d = StCount;
         StCount:   if (cyc_q == WINDOW_LAST) state_d = StEmit;
         StEmit: begin
            if (meas.meas_ready) begin
               state_d = (meas.meas_index == LAST_IDX) ? StFinish : StAdvance;
            end
         end
         StAdvance: state_d = StSettle;
         StFinish:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state, so each one tracks state_q cycle for cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= StIdle;
         cyc_q               <= '0;
         idx_reset           <= 1'b0;
         idx_increment       <= 1'b0;
         tero_en             <= 1'b0;
         busy                <= 1'b0;
         done                <= 1'b0;
         meas.meas_valid     <= 1'b0;
         meas.meas_index     <= '0;
         meas.meas_count     <= '0;
         meas.meas_challenge <= '0;
      end else begin
         state_q <= state_d;
         if ((state_d == state_q) && ((state_q == StSettle) || (state_q == StCount))) begin
            cyc_q <= cyc_q + CYC_BITS'(1);
         end else begin
            cyc_q <= '0;
         end

         idx_reset       <= (state_d == StRstIdx);
         idx_increment   <= (state_d == StAdvance);
         tero_en         <= (state_d == StSettle) || (state_d == StCount);
         busy            <= (state_d != StIdle);
         done            <= (state_d == StFinish);
         meas.meas_valid <= (state_d == StEmit);

         if ((state_q == StIdle) && start) begin
            meas.meas_challenge <= challenge_in;
         end
         if (window_end) begin
            meas.meas_index <= tero_sel;
            meas.meas_count <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_tero_sweep_ctrl.sv
// Scoreboard bench: two controllers (normal and narrow-count) driven by index-counter models.
module tb_tero_sweep_ctrl;
   import tero_pkg::*;

   localparam int unsigned NT     = 4;
   localparam int unsigned NT_B   = 2;
   localparam int          LAT    = 1 + 4 * 105 + 3 + 1;
   localparam int          BUDGET = 2000;

   typedef struct {
      meas_rec_t rec;
      int        tol;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea;
   exp_t eb;

   logic clk = 1'b0;
   logic reset;
   logic osc_slow = 1'b0;
   logic osc_fast = 1'b0;
   int   osc_mode = 2;

   logic        start_a, start_b;
   logic [3:0]  chal_a, chal_b;
   logic [31:0] sel_a = 32'h5a5a5a5a;
   logic [31:0] sel_b = 32'h5a5a5a5a;
   logic        idx_rst_a, idx_inc_a, en_a, osc_a, busy_a, done_a;
   logic        idx_rst_b, idx_inc_b, en_b, busy_b, done_b;

   int n_rst_a = 0, n_inc_a = 0, n_overlap_a = 0, n_wide_a = 0;
   logic prev_rst_a = 1'b0, prev_inc_a = 1'b0;

   always #5 clk = ~clk;
   initial begin #3; forever #50 osc_slow = ~osc_slow; end
   initial begin #3; forever #10 osc_fast = ~osc_fast; end

   assign osc_a = (osc_mode == 0) ? 1'b0 : (osc_mode == 1) ? 1'b1 : osc_slow;

   tero_sweep_ctrl_if #(.N_TERO_BITS(32), .CNT_BITS(16), .CHALLENGE_BITS(4)) bus_a ();
   tero_sweep_ctrl_if #(.N_TERO_BITS(32), .CNT_BITS(4), .CHALLENGE_BITS(4)) bus_b ();

   tero_sweep_ctrl #(
      .N_TERO_BITS(32), .N_TEROS(NT), .CHALLENGE_BITS(4),
      .SETTLE_CYCLES(4), .WINDOW_CYCLES(100), .CNT_BITS(16)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .challenge_in(chal_a), .tero_sel(sel_a),
      .idx_reset(idx_rst_a), .idx_increment(idx_inc_a), .tero_en(en_a), .tero_osc_in(osc_a),
      .busy(busy_a), .done(done_a), .meas(bus_a)
   );

   tero_sweep_ctrl #(
      .N_TERO_BITS(32), .N_TEROS(NT_B), .CHALLENGE_BITS(4),
      .SETTLE_CYCLES(4), .WINDOW_CYCLES(100), .CNT_BITS(4)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .challenge_in(chal_b), .tero_sel(sel_b),
      .idx_reset(idx_rst_b), .idx_increment(idx_inc_b), .tero_en(en_b), .tero_osc_in(osc_fast),
      .busy(busy_b), .done(done_b), .meas(bus_b)
   );

   // External TERO index counter models
   always @(posedge clk) begin
      if (idx_rst_a) sel_a <= '0;
      else if (idx_inc_a) sel_a <= sel_a + 32'd1;
      if (idx_rst_b) sel_b <= '0;
      else if (idx_inc_b) sel_b <= sel_b + 32'd1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         n_rst_a     <= n_rst_a + int'(idx_rst_a);
         n_inc_a     <= n_inc_a + int'(idx_inc_a);
         n_overlap_a <= n_overlap_a + int'(idx_rst_a & idx_inc_a);
         n_wide_a    <= n_wide_a + int'((idx_rst_a & prev_rst_a) | (idx_inc_a & prev_inc_a));
      end
      prev_rst_a <= idx_rst_a;
      prev_inc_a <= idx_inc_a;
   end

   always @(negedge clk) begin
      if (!reset && bus_a.meas_valid && bus_a.meas_ready) begin
         check("a_sb_nonempty", 64'(q_a.size() != 0), 64'd1);
         if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            check("a_index", 64'(bus_a.meas_index), 64'(ea.rec.index));
            check("a_challenge", 64'(bus_a.meas_challenge), 64'(ea.rec.challenge));
            if (ea.tol == 0) begin
               check("a_count", 64'(bus_a.meas_count), 64'(ea.rec.count));
            end else begin
               check("a_count_tol", 64'(bus_a.meas_count),
                     ((int'(bus_a.meas_count) - int'(ea.rec.count)) inside {[-ea.tol:ea.tol]})
                     ? 64'(bus_a.meas_count) : 64'(ea.rec.count));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus_b.meas_valid && bus_b.meas_ready) begin
         check("b_sb_nonempty", 64'(q_b.size() != 0), 64'd1);
         if (q_b.size() != 0) begin
            eb = q_b.pop_front();
            check("b_index", 64'(bus_b.meas_index), 64'(eb.rec.index));
            check("b_count_sat", 64'(bus_b.meas_count), 64'(eb.rec.count));
         end
      end
   end

   task automatic push_a(input logic [3:0] c, input int cnt, input int tol);
      for (int i = 0; i < int'(NT); i++) begin
         exp_t e;
         e.rec.index     = 32'(i);
         e.rec.count     = 16'(cnt);
         e.rec.challenge = c;
         e.tol           = tol;
         q_a.push_back(e);
      end
   endtask

   task automatic start_sweep_a(input logic [3:0] c);
      @(negedge clk);
      chal_a  = c;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("a_idx_reset_cycle1", 64'(idx_rst_a), 64'd1);
      check("a_busy_cycle1", 64'(busy_a), 64'd1);
   endtask

   task automatic wait_done_a(output int cyc);
      cyc = 1;
      while (done_a !== 1'b1 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("a_done_seen", 64'(done_a), 64'd1);
      @(negedge clk);
      check("a_busy_after_done", 64'(busy_a), 64'd0);
   endtask

   initial begin
      int cyc;
      int t;
      int stall_bad;
      int done_seen;
      logic [31:0] h_idx;
      logic [15:0] h_cnt;

      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      chal_a = '0; chal_b = '0;
      bus_a.meas_ready = 1'b1;
      bus_b.meas_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_valid", 64'(bus_a.meas_valid), 64'd0);
      check("rst_idx_ctl", 64'({idx_rst_a, idx_inc_a, en_a}), 64'd0);
      check("rst_meas", 64'({bus_a.meas_index, bus_a.meas_count}), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal sweep; a second start with another challenge arrives mid-sweep
      n_rst_a = 0; n_inc_a = 0;
      push_a(4'hA, 10, 1);
      start_sweep_a(4'hA);
      fork
         wait_done_a(cyc);
         begin
            repeat (200) @(negedge clk);
            chal_a = 4'h5; start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
         end
      join
      check("a_latency", 64'(cyc), 64'(LAT));
      check("a_idx_reset_once", 64'(n_rst_a), 64'd1);
      check("a_idx_inc_count", 64'(n_inc_a), 64'(NT - 1));
      check("a_idx_overlap", 64'(n_overlap_a), 64'd0);
      check("a_idx_pulse_width", 64'(n_wide_a), 64'd0);
      check("a_sb_drained1", 64'(q_a.size()), 64'd0);

      // Oscillator stuck low
      osc_mode = 0;
      push_a(4'h1, 0, 0);
      start_sweep_a(4'h1);
      wait_done_a(cyc);
      check("a_sb_drained2", 64'(q_a.size()), 64'd0);

      // Oscillator high from reset onward
      osc_mode = 1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push_a(4'h2, 0, 0);
      start_sweep_a(4'h2);
      wait_done_a(cyc);
      check("a_sb_drained3", 64'(q_a.size()), 64'd0);

      // Back-pressure on record 1
      osc_mode = 2;
      push_a(4'h3, 10, 1);
      start_sweep_a(4'h3);
      fork
         wait_done_a(cyc);
         begin
            t = 0;
            while (!(sel_a == 32'd1 && en_a) && t < BUDGET) begin @(negedge clk); t++; end
            bus_a.meas_ready = 1'b0;
            while (!bus_a.meas_valid && t < BUDGET) begin @(negedge clk); t++; end
            check("a_stall_reached", 64'(bus_a.meas_valid), 64'd1);
            h_idx = bus_a.meas_index;
            h_cnt = bus_a.meas_count;
            stall_bad = 0;
            repeat (20) begin
               @(negedge clk);
               if (!bus_a.meas_valid || bus_a.meas_index != h_idx || bus_a.meas_count != h_cnt
                   || idx_inc_a || en_a) stall_bad++;
            end
            check("a_stall_index", 64'(h_idx), 64'd1);
            check("a_stall_stable", 64'(stall_bad), 64'd0);
            bus_a.meas_ready = 1'b1;
         end
      join
      check("a_sb_drained4", 64'(q_a.size()), 64'd0);

      // Reset mid-count of index 2, then a fresh sweep
      push_a(4'h7, 10, 1);
      start_sweep_a(4'h7);
      t = 0;
      while (!(sel_a == 32'd2 && en_a) && t < BUDGET) begin @(negedge clk); t++; end
      repeat (50) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 64'(busy_a), 64'd0);
      check("abort_ctl", 64'({idx_rst_a, idx_inc_a, en_a, done_a, bus_a.meas_valid}), 64'd0);
      check("abort_meas", 64'({bus_a.meas_index, bus_a.meas_count, bus_a.meas_challenge}), 64'd0);
      check("abort_pending", 64'(q_a.size()), 64'd2);
      q_a.delete();
      done_seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (done_a || busy_a) done_seen++;
      end
      check("abort_stays_idle", 64'(done_seen), 64'd0);
      push_a(4'hC, 10, 1);
      start_sweep_a(4'hC);
      wait_done_a(cyc);
      check("a_latency_resweep", 64'(cyc), 64'(LAT));
      check("a_sb_drained5", 64'(q_a.size()), 64'd0);

      // Narrow counter saturates at 15
      for (int i = 0; i < int'(NT_B); i++) begin
         exp_t e;
         e.rec.index = 32'(i); e.rec.count = 16'd15; e.rec.challenge = 4'h9; e.tol = 0;
         q_b.push_back(e);
      end
      @(negedge clk);
      chal_b = 4'h9; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      t = 0;
      while (done_b !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
      check("b_done_seen", 64'(done_b), 64'd1);
      check("b_sb_drained", 64'(q_b.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tero_sweep_ctrl.md
Name: tero_sweep_ctrl

Overview:
Sequencer on the consumer side of the TERO index counter. It drives the counter's reset/increment inputs and reads back the current TERO index. For each index it enables the selected TERO, waits a settle time, and counts oscillator rising edges over a fixed clock window. It then emits one measurement record per TERO over a valid/ready interface to the response/PUF post-processing logic.

Parameters:
N_TERO_BITS, 32, width of the TERO index returned by the index counter
N_TEROS, 16, number of TEROs swept per challenge (indices 0..N_TEROS-1)
CHALLENGE_BITS, 4, challenge width
SETTLE_CYCLES, 16, clk cycles tero_en is high before counting (>=1)
WINDOW_CYCLES, 1024, clk cycles of the counting window (>=1)
CNT_BITS, 16, width of the edge-count result

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a sweep when idle
challenge_in  in  CHALLENGE_BITS  challenge, latched on accepted start
tero_sel  in  N_TERO_BITS  current TERO index from the index counter
idx_reset  out  1  reset pulse to the index counter
idx_increment  out  1  increment pulse to the index counter
tero_en  out  1  enable for the selected TERO
tero_osc_in  in  1  selected TERO output; asynchronous to clk
busy  out  1  high from accepted start until the cycle after done
done  out  1  one-cycle pulse after the last record is accepted
meas_valid  out  1  record valid
meas_ready  in  1  downstream ready
meas_index  out  N_TERO_BITS  index measured
meas_count  out  CNT_BITS  rising-edge count
meas_challenge  out  CHALLENGE_BITS  latched challenge

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. All outputs are 0, counters are 0, and the synchronizer flops are 0. Reset asserted mid-sweep aborts the sweep immediately; no done pulse is produced.
- FSM states: IDLE, RST_IDX, SETTLE, COUNT, EMIT, ADVANCE, FINISH. All control outputs are Moore-decoded from state.
- IDLE: start=1 latches challenge_in and moves to RST_IDX. start is ignored in every other state.
- RST_IDX (1 cycle): idx_reset=1. The counter reads 0 from the next cycle. Next state is SETTLE.
- SETTLE (SETTLE_CYCLES cycles): tero_en=1, edge counter cleared. Next state is COUNT.
- COUNT (WINDOW_CYCLES cycles): tero_en=1.
  - tero_osc_in passes through a 2-flop synchronizer into a previous-value flop that runs continuously.
  - Each cycle where the synchronized value is 1 and the previous value is 0 increments the count.
  - The count saturates at 2^CNT_BITS-1.
  - On the last window cycle, meas_index<=tero_sel and meas_count<=the final count, including any edge detected in that cycle. Next state is EMIT.
- EMIT: tero_en=0, meas_valid=1. meas_index, meas_count and meas_challenge hold stable until meas_ready=1 (transfer happens when valid&ready).
  - On transfer, if meas_index==N_TEROS-1, go to FINISH.
  - Otherwise go to ADVANCE.
  - meas_valid drops the cycle after transfer; there are no back-to-back records.
- ADVANCE (1 cycle): idx_increment=1. Next state is SETTLE, where tero_sel already shows the new index.
- FINISH (1 cycle): done=1, busy=1. Next state is IDLE.
- busy=1 in every state except IDLE.
- Sweep latency with meas_ready tied high: 1 + N_TEROS*(SETTLE_CYCLES+WINDOW_CYCLES+1) + (N_TEROS-1) + 1 cycles from start to done.
- idx_reset and idx_increment are never high in the same cycle, and each is exactly 1 cycle wide.
- Cycle counter width is $clog2(max(SETTLE_CYCLES,WINDOW_CYCLES)+1). The index compare zero-extends N_TEROS-1 to N_TERO_BITS.

Decomposition:
- Package tero_pkg: state enum typedef, default constants (N_TEROS, window/settle defaults), and a record struct {index, count, challenge}.
- Sub-module tero_edge_counter: 2FF synchronizer, edge detect, saturating counter with clear/enable inputs.
- FSM, cycle counter and output register stay in tero_sweep_ctrl.

Test Plan:
1. N_TEROS=4, SETTLE=4, WINDOW=100, meas_ready=1, osc period 10 clk for all TEROs, bench-side index counter model -> 4 records, indices 0,1,2,3. Each count is 10 (±1 for synchronizer phase). done pulses at cycle 1+4*105+3+1=425 after start.
2. tero_osc_in held at 0 -> every meas_count=0. Held at 1 from reset -> count 0 (no rising edge).
3. CNT_BITS=4, osc toggling every clk (50 edges/window) -> meas_count=15 (saturated), no wrap to small value.
4. meas_ready held low for 20 cycles in EMIT of index 1 -> meas_valid stays 1 with stable data, idx_increment stays 0, tero_en=0. Sweep then resumes normally.
5. reset pulsed mid-COUNT of index 2 -> next cycle all outputs 0, state IDLE, no done. A new start re-sweeps from idx_reset and index 0.
6. start pulsed while busy with different challenge_in -> ignored. meas_challenge keeps the original value for all records, and idx_reset is seen only once.
